// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, issues word fetches over req/ack, and presents each instruction in a one-entry slot.
// Latency: request one cycle after leaving IDLE/FULL; the slot fills on the ack edge. At most one instruction per 2 cycles.
// Backpressure: the slot holds while if_ready=0 and no fetch is issued; a redirect flushes the slot or drains an in-flight fetch.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          TIMEOUT  = 255,
    parameter int          CNT_W    = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    input  logic        if_ready,
    output logic        misalign_err,
    output logic        imem_timeout
);

    typedef enum logic [1:0] {IDLE, FETCH, FULL, DRAIN} state_t;

    localparam logic [CNT_W-1:0] TO = CNT_W'(TIMEOUT);

    state_t             state;
    logic [31:0]        pc;
    logic [31:0]        addr_q;
    logic [CNT_W-1:0]   wait_cnt;
    logic [31:0]        target;

    assign target       = {redirect_pc[31:2], 2'b00};
    assign imem_req     = (state == FETCH) || (state == DRAIN);
    assign imem_addr    = addr_q;
    assign misalign_err = !rst && redirect_valid && (redirect_pc[1:0] != 2'b00);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            pc           <= RESET_PC;
            addr_q       <= RESET_PC;
            wait_cnt     <= '0;
            imem_timeout <= 1'b0;
            if_valid     <= 1'b0;
            if_instr     <= 32'h0;
            if_pc        <= 32'h0;
        end else begin
            if (!imem_req || imem_ack)
                wait_cnt <= '0;
            else if (wait_cnt != TO)
                wait_cnt <= wait_cnt + CNT_W'(1);

            if (imem_req && wait_cnt == TO)
                imem_timeout <= 1'b1;

            if (redirect_valid)
                pc <= target;

            case (state)
                IDLE: begin
                    addr_q <= redirect_valid ? target : pc;
                    state  <= FETCH;
                end
                FETCH: begin
                    if (redirect_valid) begin
                        // An un-acked request cannot be withdrawn, so it is drained instead.
                        if (imem_ack)
                            addr_q <= target;
                        else
                            state <= DRAIN;
                    end else if (imem_ack) begin
                        if_instr <= imem_rdata;
                        if_pc    <= addr_q;
                        if_valid <= 1'b1;
                        pc       <= addr_q + 32'd4;
                        state    <= FULL;
                    end
                end
                FULL: begin
                    if (redirect_valid || if_ready) begin
                        if_valid <= 1'b0;
                        addr_q   <= redirect_valid ? target : pc;
                        state    <= FETCH;
                    end
                end
                DRAIN: begin
                    // Wrong-path data is discarded; restart from the (possibly just redirected) PC.
                    if (imem_ack) begin
                        addr_q <= redirect_valid ? target : pc;
                        state  <= FETCH;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: a behavioural memory with programmable wait states, expected requests and slot outputs queued ahead.
module tb_fetch_ctrl;

    logic        clk;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_ready;
    logic        misalign_err;
    logic        imem_timeout;

    fetch_ctrl #(.RESET_PC(32'h0000_3000), .TIMEOUT(4), .CNT_W(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .if_valid       (if_valid),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .if_ready       (if_ready),
        .misalign_err   (misalign_err),
        .imem_timeout   (imem_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          extra_out = 0;
    int          mem_wait = 0;
    logic        mem_hold = 1'b0;
    int          seen = 0;
    logic        in_txn = 1'b0;
    logic [31:0] txn_addr = 32'h0;
    logic [31:0] exp_req[$];
    logic [31:0] exp_out[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge after inputs are set: memory reply, scoreboard, then advance one cycle.
    task automatic step();
        logic [31:0] e;
        #1;
        if (!imem_req) begin
            imem_ack = 1'b0;
            in_txn   = 1'b0;
            seen     = 0;
        end else begin
            if (!in_txn) begin
                in_txn   = 1'b1;
                seen     = 0;
                txn_addr = imem_addr;
                if (exp_req.size() > 0) begin
                    e = exp_req.pop_front();
                    check("req_addr", imem_addr, e);
                end
            end else begin
                check("addr_hold", imem_addr, txn_addr);
            end
            imem_ack   = !mem_hold && (seen >= mem_wait);
            imem_rdata = imem_ack ? mem_word(imem_addr) : 32'hDEAD_BEEF;
            if (imem_ack) in_txn = 1'b0;
            else          seen++;
        end
        if (if_valid && if_ready) begin
            if (exp_out.size() == 0) begin
                extra_out++;
            end else begin
                e = exp_out.pop_front();
                check("out_pc", if_pc, e);
                check("out_instr", if_instr, mem_word(e));
            end
        end
        @(negedge clk);
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, "_req"},      {31'h0, imem_req},     32'h0);
        check({tag, "_valid"},    {31'h0, if_valid},     32'h0);
        check({tag, "_instr"},    if_instr,              32'h0);
        check({tag, "_pc"},       if_pc,                 32'h0);
        check({tag, "_misalign"}, {31'h0, misalign_err}, 32'h0);
        check({tag, "_timeout"},  {31'h0, imem_timeout}, 32'h0);
    endtask

    initial begin
        int n;
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        imem_ack       = 1'b0;
        imem_rdata     = 32'h0;
        if_ready       = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_reset_outs("rst");

        // Zero-wait streaming: one instruction every two cycles.
        mem_wait = 0;
        exp_req.push_back(32'h3000); exp_req.push_back(32'h3004);
        exp_req.push_back(32'h3008); exp_req.push_back(32'h300C);
        exp_out.push_back(32'h3000); exp_out.push_back(32'h3004);
        exp_out.push_back(32'h3008);
        rst      = 1'b0;
        if_ready = 1'b1;
        n = 0;
        while (exp_out.size() > 0 && n < 40) begin
            step();
            n++;
        end
        check("stream_cycles", n, 7);

        // Stall: slot holds and no fetch is issued.
        if_ready = 1'b0;
        step();
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", {31'h0, if_valid}, 32'h1);
            check("stall_pc",    if_pc,             32'h300C);
            check("stall_instr", if_instr,          mem_word(32'h300C));
            check("stall_req",   {31'h0, imem_req}, 32'h0);
            step();
        end
        exp_out.push_back(32'h300C);
        exp_req.push_back(32'h3010);
        if_ready = 1'b1;
        step();
        if_ready = 1'b0;
        step();

        // Redirect during a 3-wait-state fetch: old request drains, data never shown.
        mem_wait = 3;
        exp_out.push_back(32'h3010);
        exp_req.push_back(32'h3014);
        exp_req.push_back(32'h3100);
        if_ready = 1'b1;
        step();
        if_ready = 1'b0;
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h3100;
        step();
        redirect_valid = 1'b0;
        check("drain_req",  {31'h0, imem_req}, 32'h1);
        check("drain_addr", imem_addr,         32'h3014);
        n = 0;
        while (!if_valid && n < 20) begin
            step();
            n++;
        end
        check("drain_cycles", n, 6);
        check("drain_pc",     if_pc,    32'h3100);
        check("drain_instr",  if_instr, mem_word(32'h3100));
        exp_out.push_back(32'h3100);

        // Redirect in the ack cycle: data dropped, new request immediately.
        mem_wait = 0;
        if_ready = 1'b1;
        step();
        if_ready = 1'b0;
        exp_req.push_back(32'h3104);
        exp_req.push_back(32'h3040);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h3040;
        step();
        redirect_valid = 1'b0;
        check("ackredir_req",   {31'h0, imem_req}, 32'h1);
        check("ackredir_addr",  imem_addr,         32'h3040);
        check("ackredir_valid", {31'h0, if_valid}, 32'h0);
        step();
        check("ackredir_slot", {31'h0, if_valid}, 32'h1);
        check("ackredir_pc",   if_pc,             32'h3040);

        // Misaligned redirect while the slot is full: pulse, flush, aligned fetch.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h3042;
        #1;
        check("misalign_on", {31'h0, misalign_err}, 32'h1);
        step();
        redirect_valid = 1'b0;
        #1;
        check("misalign_off",   {31'h0, misalign_err}, 32'h0);
        check("misalign_flush", {31'h0, if_valid},     32'h0);
        check("misalign_addr",  imem_addr,             32'h3040);
        step();
        check("misalign_pc", if_pc, 32'h3040);
        exp_out.push_back(32'h3040);
        if_ready = 1'b1;
        step();
        if_ready = 1'b0;

        // Timeout: ack withheld on 0x3044.
        mem_hold = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("to_early", {31'h0, imem_timeout}, 32'h0);
            step();
        end
        check("to_set", {31'h0, imem_timeout}, 32'h1);
        mem_hold = 1'b0;
        step();
        check("to_sticky", {31'h0, imem_timeout}, 32'h1);
        check("to_pc",     if_pc,                 32'h3044);
        exp_out.push_back(32'h3044);
        if_ready = 1'b1;
        step();
        if_ready = 1'b0;

        // PC wrap past 0xFFFF_FFFC.
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        check("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
        step();
        check("wrap_slot", if_pc, 32'hFFFF_FFFC);
        exp_out.push_back(32'hFFFF_FFFC);
        if_ready = 1'b1;
        step();
        if_ready = 1'b0;
        check("wrap_req",  {31'h0, imem_req}, 32'h1);
        check("wrap_addr", imem_addr,         32'h0000_0000);

        // Reset in the middle of a waiting fetch.
        mem_hold = 1'b1;
        step();
        rst = 1'b1;
        #1;
        check_reset_outs("midrst");
        step();
        step();
        check_reset_outs("inrst");
        mem_hold = 1'b0;
        exp_req.push_back(32'h3000);
        rst = 1'b0;
        step();
        step();
        check("restart_valid", {31'h0, if_valid}, 32'h1);
        check("restart_pc",    if_pc,             32'h3000);

        check("out_left",  exp_out.size(), 0);
        check("req_left",  exp_req.size(), 0);
        check("extra_out", extra_out,      0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
